// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with start/busy/done handshake and iterative shift-add multiply
module alu_seq #(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opCode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aOut,
    output logic             overFlow,
    output logic             zero,
    output logic             illegalOp
);

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, next_state;
    logic [2*WIDTH-1:0]   mcand, acc, acc_next;
    logic [WIDTH-1:0]     mplier;
    logic [CNTW-1:0]      cnt;
    logic                 mul_last, mul_ovf;
    logic [WIDTH:0]       sum;
    logic                 shl_lost;
    logic [WIDTH-1:0]     sc_val;
    logic                 sc_ovf, sc_ill;

    assign busy     = (state == MUL);
    assign mul_last = (state == MUL) && (cnt == CNTW'(WIDTH - 1));
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_ovf  = |acc_next[2*WIDTH-1:WIDTH];
    assign sum      = {1'b0, a} + {1'b0, b};

    // A left shift loses bits if shifting back does not restore the operand.
    assign shl_lost = (b >= WIDTH'(WIDTH)) ? (a != '0) : (((a << b) >> b) != a);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && opCode == OP_MUL) next_state = MUL;
            MUL:     if (mul_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sc_val = aOut;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (opCode)
            OP_ADD: if (sum[WIDTH]) sc_ovf = 1'b1; else sc_val = sum[WIDTH-1:0];
            OP_SUB: if (a < b) sc_ovf = 1'b1; else sc_val = a - b;
            OP_OR:  sc_val = a | b;
            OP_AND: sc_val = a & b;
            OP_NOT: sc_val = ~a;
            OP_SHL: if (shl_lost) sc_ovf = 1'b1; else sc_val = a << b;
            OP_SHR: sc_val = a >> b;
            OP_MUL: sc_val = aOut;
            default: sc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aOut      <= '0;
            overFlow  <= 1'b0;
            zero      <= 1'b1;
            illegalOp <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                if (opCode == OP_MUL) begin
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    aOut      <= sc_val;
                    overFlow  <= sc_ovf;
                    illegalOp <= sc_ill;
                    zero      <= (sc_val == '0);
                    done      <= 1'b1;
                end
            end else if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // Last iteration folds its partial product straight into the result.
                if (mul_last) begin
                    done      <= 1'b1;
                    overFlow  <= mul_ovf;
                    illegalOp <= 1'b0;
                    if (!mul_ovf) aOut <= acc_next[WIDTH-1:0];
                    zero <= ((mul_ovf ? aOut : acc_next[WIDTH-1:0]) == '0);
                end
            end
        end
    end

endmodule
